// File: rtl/tdc_output_arbiter.sv
// -----------------------------------------------------------------------------
// tdc_output_arbiter
//   Collects TDC events from NUM_CHANNELS channels into small per-channel skid
//   buffers and drains them round-robin into a shared event FIFO. Every word
//   written is tagged with its channel ID. Events that arrive while a channel
//   buffer is full and not being drained are dropped and counted (saturating).
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   ch_valid     in   per-channel event strobe, one cycle per event
//   ch_data      in   channel i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   enable_mask  in   1 = channel captures events
//   clear_counts in   synchronous clear of all drop counters
//   fifo_full    in   downstream event FIFO full; blocks the grant
//   ch_ready     out  channel buffer not full
//   fifo_write   out  write strobe to the event FIFO
//   fifo_wdata   out  {channel_id, payload}; holds last value when idle
//   sel_onehot   out  one-hot granted channel, valid with fifo_write
//   drop_count   out  per-channel dropped-event counters, CNT_WIDTH each
// -----------------------------------------------------------------------------
module tdc_output_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 64,
    parameter int ID_WIDTH     = 4,
    parameter int SKID_DEPTH   = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CHANNELS-1:0]            ch_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CHANNELS-1:0]            enable_mask,
    input  logic                               clear_counts,
    input  logic                               fifo_full,
    output logic [NUM_CHANNELS-1:0]            ch_ready,
    output logic                               fifo_write,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]     fifo_wdata,
    output logic [NUM_CHANNELS-1:0]            sel_onehot,
    output logic [NUM_CHANNELS*CNT_WIDTH-1:0]  drop_count
);

    localparam int OUT_WIDTH = ID_WIDTH + DATA_WIDTH;
    localparam int PTR_W     = $clog2(NUM_CHANNELS);
    localparam int AW        = $clog2(SKID_DEPTH);
    localparam int OCC_W     = AW + 1;
    localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(SKID_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    // Channel index base+k, wrapped modulo NUM_CHANNELS (need not be a power of 2).
    function automatic logic [PTR_W-1:0] rr_offset(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_CHANNELS) s = s - NUM_CHANNELS;
        return PTR_W'(s);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q    [NUM_CHANNELS][SKID_DEPTH];
    logic [AW-1:0]         wr_ptr_q [NUM_CHANNELS];
    logic [AW-1:0]         wr_ptr_d [NUM_CHANNELS];
    logic [AW-1:0]         rd_ptr_q [NUM_CHANNELS];
    logic [AW-1:0]         rd_ptr_d [NUM_CHANNELS];
    logic [OCC_W-1:0]      occ_q    [NUM_CHANNELS];
    logic [OCC_W-1:0]      occ_d    [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]  drop_q   [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]  drop_d   [NUM_CHANNELS];
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [OUT_WIDTH-1:0]  wdata_q,  wdata_d;

    logic [NUM_CHANNELS-1:0] nonempty, full, push, pop, drop;
    logic                    grant_found, grant;
    logic [PTR_W-1:0]        grant_idx;

    // Buffer status, purely from registered occupancy.
    always_comb begin
        nonempty = '0;
        full     = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            nonempty[i] = (occ_q[i] != '0);
            full[i]     = (occ_q[i] == OCC_FULL);
        end
    end

    assign ch_ready = ~full;

    // Round-robin search: first non-empty channel starting at rr_ptr.
    // NOTE: every variable written in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (!grant_found && nonempty[rr_offset(rr_ptr_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_offset(rr_ptr_q, k);
            end
        end
    end

    // Gating with reset keeps a buffered word from escaping in the reset cycle.
    assign grant = grant_found && !fifo_full && !reset;

    always_comb begin
        pop = '0;
        if (grant) pop[grant_idx] = 1'b1;
    end

    assign sel_onehot = pop;
    assign fifo_write = grant;

    always_comb begin
        wdata_d  = wdata_q;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            wdata_d  = {ID_WIDTH'(grant_idx), mem_q[grant_idx][rd_ptr_q[grant_idx]]};
            rr_ptr_d = rr_offset(grant_idx, 1);
        end
    end

    assign fifo_wdata = wdata_d;

    // Per-channel capture, drop detection and pointer/occupancy update.
    // A full buffer that is popped this cycle still accepts the push.
    always_comb begin
        push = '0;
        drop = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            push[i]     = ch_valid[i] && enable_mask[i] && (!full[i] || pop[i]);
            drop[i]     = ch_valid[i] && enable_mask[i] && full[i] && !pop[i];
            wr_ptr_d[i] = wr_ptr_q[i] + AW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AW'(pop[i]);
            occ_d[i]    = occ_q[i] + OCC_W'(push[i]) - OCC_W'(pop[i]);
            // Clear has priority over a simultaneous drop; counters saturate.
            if (clear_counts)                          drop_d[i] = '0;
            else if (drop[i] && drop_q[i] != CNT_MAX)  drop_d[i] = drop_q[i] + 1'b1;
            else                                       drop_d[i] = drop_q[i];
        end
    end

    always_comb begin
        drop_count = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            drop_count[i*CNT_WIDTH +: CNT_WIDTH] = drop_q[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
                drop_q[i]   <= '0;
            end
            rr_ptr_q <= '0;
            wdata_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                occ_q[i]    <= occ_d[i];
                drop_q[i]   <= drop_d[i];
            end
            rr_ptr_q <= rr_ptr_d;
            wdata_q  <= wdata_d;
        end
    end

    // NOTE: buffer storage is deliberately not reset; occupancy decides what is
    // valid, and leaving the array reset-free lets it map to plain storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_tdc_output_arbiter.sv
// Self-checking bench for tdc_output_arbiter (4 channels, 64-bit payload,
// 2-deep skid buffers, 4-bit drop counters so saturation is reachable).
module tb_tdc_output_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int SD = 2;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      ch_valid;
    logic [N*DW-1:0]   ch_data;
    logic [N-1:0]      enable_mask;
    logic              clear_counts;
    logic              fifo_full;
    logic [N-1:0]      ch_ready;
    logic              fifo_write;
    logic [IW+DW-1:0]  fifo_wdata;
    logic [N-1:0]      sel_onehot;
    logic [N*CW-1:0]   drop_count;

    always #5 clk = ~clk;

    tdc_output_arbiter #(
        .NUM_CHANNELS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .SKID_DEPTH(SD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
        .enable_mask(enable_mask), .clear_counts(clear_counts), .fifo_full(fifo_full),
        .ch_ready(ch_ready), .fifo_write(fifo_write), .fifo_wdata(fifo_wdata),
        .sel_onehot(sel_onehot), .drop_count(drop_count)
    );

    typedef struct packed {
        logic [IW+DW-1:0] word;
        logic [N-1:0]     sel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   writes_seen = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] dc(input int i);
        return drop_count[i*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_word(input int ch, input logic [DW-1:0] d);
        exp_t e;
        e.word = {IW'(ch), d};
        e.sel  = N'(1) << ch;
        sb.push_back(e);
    endtask

    // One-cycle event on channel ch; returns just after the capturing edge.
    task automatic pulse1(input int ch, input logic [DW-1:0] d);
        ch_valid = '0;
        ch_valid[ch] = 1'b1;
        ch_data[ch*DW +: DW] = d;
        tick();
        ch_valid = '0;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Scoreboard side: every DUT write must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && fifo_write === 1'b1) begin
            writes_seen++;
            check("sb_expected_write", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("sb_wdata", fifo_wdata, mon_e.word);
                check("sb_sel", sel_onehot, mon_e.sel);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int model;
        int order [N];
        logic [DW-1:0] dd [N];
        order = '{2, 3, 0, 1};

        reset = 1'b1; ch_valid = '0; ch_data = '0; enable_mask = '1;
        clear_counts = 1'b0; fifo_full = 1'b0;

        // T1: reset held with ch_valid toggling
        for (int c = 0; c < 3; c++) begin
            tick();
            ch_valid = c[0] ? 4'b1010 : 4'b0101;
            sample();
            check("t1_write", fifo_write, 0);
            check("t1_sel", sel_onehot, 0);
            check("t1_ready", ch_ready, 4'b1111);
            check("t1_drops", drop_count, 0);
            check("t1_wdata", fifo_wdata, 0);
        end
        tick();
        reset = 1'b0; ch_valid = '0;

        // T2: single event on ch2 appears the cycle after capture
        tick();
        expect_word(2, 64'hABCD);
        pulse1(2, 64'hABCD);
        sample();
        check("t2_write", fifo_write, 1);
        check("t2_sel", sel_onehot, 4'b0100);
        check("t2_wdata", fifo_wdata, {4'd2, 64'hABCD});
        tick();
        check("t2_idle", fifo_write, 0);
        check("t2_hold", fifo_wdata, {4'd2, 64'hABCD});
        repeat (2) tick();

        // T3: drain ch1 (rr_ptr -> 2), then all four at once -> 2,3,0,1 back-to-back
        dd[0] = rnd64();
        expect_word(1, dd[0]);
        pulse1(1, dd[0]);
        tick();
        for (int c = 0; c < N; c++) dd[c] = rnd64();
        for (int k = 0; k < N; k++) expect_word(order[k], dd[order[k]]);
        for (int c = 0; c < N; c++) ch_data[c*DW +: DW] = dd[c];
        ch_valid = '1;
        tick();
        ch_valid = '0;
        for (int k = 0; k < N; k++) begin
            sample();
            check("t3_write", fifo_write, 1);
            check("t3_sel", sel_onehot, N'(1) << order[k]);
        end
        tick();

        // T4: overflow while fifo_full, then drain in arrival order
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) dd[c] = rnd64();
        for (int c = 0; c < 3; c++) pulse1(0, dd[c]);
        sample();
        check("t4_blocked", fifo_write, 0);
        check("t4_ready", ch_ready, 4'b1110);
        check("t4_drop", dc(0), 1);
        tick();
        expect_word(0, dd[0]);
        expect_word(0, dd[1]);
        w = writes_seen;
        fifo_full = 1'b0;
        repeat (4) tick();
        check("t4_writes", writes_seen - w, 2);
        check("t4_ready_after", ch_ready, 4'b1111);

        // T4b: full buffer popped in the same cycle as a push -> accepted, no drop
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) dd[c] = rnd64();
        pulse1(0, dd[0]);
        pulse1(0, dd[1]);
        for (int c = 0; c < 3; c++) expect_word(0, dd[c]);
        w = writes_seen;
        fifo_full = 1'b0;
        pulse1(0, dd[2]);
        repeat (4) tick();
        check("t4b_writes", writes_seen - w, 3);
        check("t4b_drop", dc(0), 1);

        // T5: masked channel ignores events
        enable_mask = 4'b1101;
        w = writes_seen;
        pulse1(1, rnd64());
        repeat (3) tick();
        check("t5_mask_writes", writes_seen - w, 0);
        check("t5_mask_drop", dc(1), 0);
        check("t5_mask_ready", ch_ready, 4'b1111);
        enable_mask = '1;

        // T5b: clear coinciding with a ch0 drop -> counter reads 0
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) dd[c] = rnd64();
        pulse1(0, dd[0]);
        pulse1(0, dd[1]);
        clear_counts = 1'b1;
        pulse1(0, dd[2]);
        clear_counts = 1'b0;
        sample();
        check("t5_clear", dc(0), 0);
        tick();
        expect_word(0, dd[0]);
        expect_word(0, dd[1]);
        w = writes_seen;
        fifo_full = 1'b0;
        repeat (4) tick();
        check("t5_drain", writes_seen - w, 2);

        // T6: saturation of drop_count[3]
        fifo_full = 1'b1;
        pulse1(3, rnd64());
        pulse1(3, rnd64());
        model = 0;
        for (int k = 0; k < 17; k++) begin
            pulse1(3, rnd64());
            if (model < (1 << CW) - 1) model++;
            check("t6_sat", dc(3), model);
        end
        check("t6_ready", ch_ready, 4'b0111);

        // T6b: reset with 2 events buffered -> they never appear
        reset = 1'b1;
        tick();
        fifo_full = 1'b0;
        tick();
        reset = 1'b0;
        w = writes_seen;
        repeat (5) tick();
        check("t6_no_writes", writes_seen - w, 0);
        check("t6_ready_rst", ch_ready, 4'b1111);
        check("t6_drop_rst", dc(3), 0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
